adder_join: RTL and testbench

Parametrised N-channel join-and-add stage, the successor to the fixed two-input registered adder in the top-level datapath. Each of CH_N input channels has its own valid/ready handshake and a small elastic FIFO, so operands need not arrive in the same cycle. When every channel holds a word, one word is popped from each channel and their sum is registered onto a valid/ready output. The block sits between the input registers and the output register stage, and replaces the "add only when both valids coincide" behaviour.

---
 rtl/adder_join_if.sv | 39 +++
 rtl/adder_join.sv | 145 ++++++++++++++
 tb/tb_adder_join.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_join_if.sv
// ----------------------------------------------------------------------------
// adder_join_if
//   Handshake bundle for the adder_join stage: per-channel input valid/ready
//   with packed operands, the registered-sum output handshake, and flush.
//
//   flush      1            synchronous clear of the whole stage
//   in_data    CH_N*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   in_valid   CH_N         per-channel valid
//   in_ready   CH_N         per-channel ready (channel FIFO not full)
//   out_data   OUT_W        registered sum
//   out_valid  1            registered sum is valid
//   out_ready  1            downstream accepts out_data
//
//   master: producer/consumer side; slave: the adder_join stage itself.
// ----------------------------------------------------------------------------
interface adder_join_if #(
    parameter int DATA_W = 16,
    parameter int CH_N   = 2
);
    localparam int OUT_W = DATA_W + $clog2(CH_N);

    logic                     flush;
    logic [CH_N*DATA_W-1:0]   in_data;
    logic [CH_N-1:0]          in_valid;
    logic [CH_N-1:0]          in_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/adder_join.sv
// ----------------------------------------------------------------------------
// adder_join
//   N-channel join-and-add stage. Each channel buffers operands in its own
//   elastic FIFO so operands may arrive skewed. When every channel holds a
//   word, one word is popped from each and their extended sum is registered
//   onto a valid/ready output.
//
//   clk   single clock
//   rst   asynchronous, active-high reset of pointers, counts, output register
//   bus   adder_join_if.slave (flush, in_data/in_valid/in_ready,
//         out_data/out_valid/out_ready)
//
//   Parameters: DATA_W operand width, CH_N channels (2..8), FIFO_DEPTH entries
//   per channel (power of 2, >= 2), SIGNED selects sign- vs zero-extension.
// ----------------------------------------------------------------------------
module adder_join #(
    parameter int DATA_W     = 16,
    parameter int CH_N       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SIGNED     = 0
) (
    input  logic           clk,
    input  logic           rst,
    adder_join_if.slave    bus
);
    localparam int OUT_W = DATA_W + $clog2(CH_N);
    localparam int EXT_W = OUT_W - DATA_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q    [CH_N][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [CH_N];
    logic [PTR_W-1:0]  wr_ptr_d [CH_N];
    logic [PTR_W-1:0]  rd_ptr_q [CH_N];
    logic [PTR_W-1:0]  rd_ptr_d [CH_N];
    logic [CNT_W-1:0]  cnt_q    [CH_N];
    logic [CNT_W-1:0]  cnt_d    [CH_N];

    logic [CH_N-1:0]   ready;
    logic [CH_N-1:0]   not_empty;
    logic [CH_N-1:0]   push;
    logic              fire;
    logic [DATA_W-1:0] head;
    logic [OUT_W-1:0]  sum;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    // Ready is decoded from the registered count only, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        ready     = '0;
        not_empty = '0;
        push      = '0;
        for (int i = 0; i < CH_N; i++) begin
            ready[i]     = (cnt_q[i] != FULL);
            not_empty[i] = (cnt_q[i] != '0);
            push[i]      = bus.in_valid[i] && ready[i] && !bus.flush;
        end
    end

    // The only combinational path from out_ready: it frees the output
    // register and therefore allows a pop in the same cycle.
    assign fire = (&not_empty) && (!out_valid_q || bus.out_ready) && !bus.flush;

    // Sum of the FIFO heads, each extended to OUT_W so the sum cannot overflow.
    always_comb begin
        sum  = '0;
        head = '0;
        for (int i = 0; i < CH_N; i++) begin
            head = mem_q[i][rd_ptr_q[i]];
            if (SIGNED != 0) begin
                sum = sum + {{EXT_W{head[DATA_W-1]}}, head};
            end else begin
                sum = sum + {{EXT_W{1'b0}}, head};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH_N; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (bus.flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end else begin
                // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
                if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                if (fire)    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                if (push[i] && !fire)      cnt_d[i] = cnt_q[i] + CNT_W'(1);
                else if (!push[i] && fire) cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next-state values from the same clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < CH_N; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; entries are only ever read after a
    // push has written them, so clearing pointers and counts is sufficient.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_N; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_adder_join.sv
// ----------------------------------------------------------------------------
// tb_adder_join
//   Three adder_join instances: A (CH_N=2, DATA_W=16, unsigned) carries the
//   scoreboard, B (CH_N=4) the skew case, C (CH_N=3, DATA_W=8, signed) the
//   sign-extension case. Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_adder_join;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   outs_a   = 0;

    adder_join_if #(.DATA_W(16), .CH_N(2)) ifa ();
    adder_join_if #(.DATA_W(16), .CH_N(4)) ifb ();
    adder_join_if #(.DATA_W(8),  .CH_N(3)) ifc ();

    adder_join #(.DATA_W(16), .CH_N(2), .FIFO_DEPTH(4), .SIGNED(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    adder_join #(.DATA_W(16), .CH_N(4), .FIFO_DEPTH(4), .SIGNED(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    adder_join #(.DATA_W(8),  .CH_N(3), .FIFO_DEPTH(4), .SIGNED(1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard for instance A ----------------
    logic [15:0] chq0[$];
    logic [15:0] chq1[$];
    logic [16:0] expq[$];

    always @(negedge clk) begin : sb_a
        logic [16:0] exp_v;
        if (rst) begin
            chq0.delete(); chq1.delete(); expq.delete();
        end else begin
            if (ifa.out_valid && ifa.out_ready) begin
                outs_a++;
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_extra: got out_data=%h, expected no output", ifa.out_data);
                end else begin
                    exp_v = expq.pop_front();
                    if (ifa.out_data !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_a_data: got %h, expected %h", ifa.out_data, exp_v);
                    end
                end
            end
            if (ifa.flush) begin
                chq0.delete(); chq1.delete(); expq.delete();
            end else begin
                if (ifa.in_valid[0] && ifa.in_ready[0]) chq0.push_back(ifa.in_data[15:0]);
                if (ifa.in_valid[1] && ifa.in_ready[1]) chq1.push_back(ifa.in_data[31:16]);
                while (chq0.size() > 0 && chq1.size() > 0) begin
                    exp_v = {1'b0, chq0.pop_front()} + {1'b0, chq1.pop_front()};
                    expq.push_back(exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_data !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%h, expected 0/0", ifa.out_valid, ifa.out_data);
        end
        n_checks++;
        if (ifa.in_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b, expected 11", ifa.in_ready);
        end
        n_checks++;
        if (ifb.out_valid !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bc: b=%b c=%b, expected 0", ifb.out_valid, ifc.out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_aligned();
        ifa.in_data  = {16'h0001, 16'hFFFF};
        ifa.in_valid = 2'b11;
        tick();
        ifa.in_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL aligned_lat1: out_valid=%b, expected 0", ifa.out_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_data !== 17'h10000) begin
            n_fail++;
            $display("FAIL aligned_sum: valid=%b data=%h, expected 1/10000", ifa.out_valid, ifa.out_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL aligned_drop: out_valid=%b, expected 0", ifa.out_valid);
        end
    endtask

    task automatic test_skew();
        ifb.in_data  = {16'd4, 16'd3, 16'd2, 16'd1};
        ifb.in_valid = 4'b0111;
        tick();
        ifb.in_valid = 4'b0000;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            n_checks++;
            if (ifb.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL skew_early: cycle %0d out_valid=%b, expected 0", e, ifb.out_valid);
            end
            if (e < 4) tick();
        end
        tick();
        ifb.in_valid = 4'b1000;
        tick();
        ifb.in_valid = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (ifb.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_lat: out_valid=%b, expected 0", ifb.out_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ifb.out_valid !== 1'b1 || ifb.out_data !== 18'd10) begin
            n_fail++;
            $display("FAIL skew_sum: valid=%b data=%0d, expected 1/10", ifb.out_valid, ifb.out_data);
        end
        for (int e = 0; e < 4; e++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 4'hF) begin
                n_fail++;
                $display("FAIL skew_single: valid=%b ready=%b, expected 0/1111", ifb.out_valid, ifb.in_ready);
            end
        end
    endtask

    task automatic test_signed();
        // -128 + -128 + 127 = -129, then 127 * 3 = 381
        ifc.in_data  = {8'h7F, 8'h80, 8'h80};
        ifc.in_valid = 3'b111;
        tick();
        ifc.in_data  = {8'h7F, 8'h7F, 8'h7F};
        tick();
        ifc.in_valid = 3'b000;
        @(negedge clk);
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 10'h37F) begin
            n_fail++;
            $display("FAIL signed_neg: valid=%b data=%h, expected 1/37f", ifc.out_valid, ifc.out_data);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 10'h17D) begin
            n_fail++;
            $display("FAIL signed_pos: valid=%b data=%h, expected 1/17d", ifc.out_valid, ifc.out_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int   sent [2];
        logic [1:0] rdy;
        sent[0] = 0; sent[1] = 0;
        ifa.out_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int ch = 0; ch < 2; ch++) begin
                ifa.in_valid[ch] = (sent[ch] < 6);
                ifa.in_data[ch*16 +: 16] = (ch == 0) ? 16'(16'h0100 + sent[0]) : 16'(16'h2000 + 3 * sent[1]);
            end
            rdy = ifa.in_ready;
            tick();
            for (int ch = 0; ch < 2; ch++)
                if (ifa.in_valid[ch] && rdy[ch]) sent[ch]++;
        end
        @(negedge clk);
        n_checks++;
        if (sent[0] != 5 || sent[1] != 5) begin
            n_fail++;
            $display("FAIL bp_accepted: ch0=%0d ch1=%0d, expected 5/5", sent[0], sent[1]);
        end
        n_checks++;
        if (ifa.in_ready !== 2'b00 || ifa.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b, expected 00/1", ifa.in_ready, ifa.out_valid);
        end
        tick();
        ifa.in_valid  = 2'b00;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifa.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_drain: beat %0d out_valid=%b, expected 1", i, ifa.out_valid);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: out_valid=%b pending=%0d, expected 0/0", ifa.out_valid, expq.size());
        end
    endtask

    task automatic fill_four();
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            ifa.in_data = {16'(16'h0400 + i), 16'(16'h0030 + i)};
            tick();
        end
    endtask

    task automatic test_flush();
        fill_four();
        ifa.flush   = 1'b1;
        ifa.in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: out_valid=%b, expected 1", ifa.out_valid);
        end
        tick();
        ifa.flush    = 1'b0;
        ifa.in_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b, expected 0/11", ifa.out_valid, ifa.in_ready);
        end
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (ifa.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale: cycle %0d out_valid=%b, expected 0", i, ifa.out_valid);
            end
        end
    endtask

    task automatic test_rst_async();
        fill_four();
        ifa.in_valid = 2'b00;
        #2;
        n_checks++;
        if (ifa.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: out_valid=%b, expected 1", ifa.out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_data !== 17'h0 || ifa.in_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%h ready=%b, expected 0/0/11",
                     ifa.out_valid, ifa.out_data, ifa.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (ifa.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale: cycle %0d out_valid=%b, expected 0", i, ifa.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] vld;
        logic [1:0] acc;
        int         outs_start;
        int         guard;
        vld = 2'b00;
        acc = 2'b00;
        outs_start = outs_a;
        for (int c = 0; c < 10000; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!vld[ch] || acc[ch]) begin
                    vld[ch] = 1'($urandom_range(0, 1));
                    ifa.in_data[ch*16 +: 16] = 16'($urandom);
                end
            end
            ifa.in_valid  = vld;
            ifa.out_ready = 1'($urandom_range(0, 1));
            acc = vld & ifa.in_ready;
            tick();
        end
        ifa.in_valid  = 2'b00;
        ifa.out_ready = 1'b1;
        guard = 0;
        while ((expq.size() != 0 || ifa.out_valid) && guard < 40) begin
            tick();
            guard++;
        end
        @(negedge clk);
        n_checks++;
        if (expq.size() != 0 || ifa.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: pending=%0d out_valid=%b, expected 0/0", expq.size(), ifa.out_valid);
        end
        n_checks++;
        if (outs_a - outs_start < 1000) begin
            n_fail++;
            $display("FAIL random_volume: got %0d sums, expected at least 1000", outs_a - outs_start);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.flush = 1'b0; ifa.in_data = '0; ifa.in_valid = '0; ifa.out_ready = 1'b1;
        ifb.flush = 1'b0; ifb.in_data = '0; ifb.in_valid = '0; ifb.out_ready = 1'b1;
        ifc.flush = 1'b0; ifc.in_data = '0; ifc.in_valid = '0; ifc.out_ready = 1'b1;
        test_reset();
        test_aligned();
        test_skew();
        test_signed();
        test_backpressure();
        test_flush();
        test_rst_async();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
